aging_monitor: RTL and testbench

Round-robin scheduler and evaluator for the ring-oscillator aging sensors. Every idle period it clears, enables and reads each sensor's frequency counter in turn for a fixed reference-clock window. It then compares each count against the aging threshold and reports per-sensor results plus an "aged" flag vector. It sits directly downstream of the sensor array and upstream of the reconfiguration logic that consumes the aged flags.

---
 rtl/aging_monitor_pkg.sv | 38 +++
 rtl/monitor_timer.sv | 35 +++
 rtl/aging_monitor.sv | 166 ++++++++++++++++
 tb/tb_aging_monitor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/aging_monitor_pkg.sv
// rtl/aging_monitor_pkg.sv - shared state type and default parameters for the aging monitor
package aging_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MEASURE,
        ST_SETTLE,
        ST_EVAL
    } monitor_state_t;

`ifndef COUNT_AGING_SENSORS
`define COUNT_AGING_SENSORS 2
`endif

`ifndef COUNTER_WIDTH
`define COUNTER_WIDTH 32
`endif

`ifndef MEASUREMENT_DURATION
`define MEASUREMENT_DURATION 1000000
`endif

`ifndef DURATION_IDLE_MODE
`define DURATION_IDLE_MODE 16
`endif

`ifndef AGING_THRESHOLD
`define AGING_THRESHOLD 6
`endif

    localparam int DEFAULT_SENSOR_COUNT    = `COUNT_AGING_SENSORS;
    localparam int DEFAULT_COUNTER_WIDTH   = `COUNTER_WIDTH;
    localparam int DEFAULT_MEAS_CYCLES     = `MEASUREMENT_DURATION;
    localparam int DEFAULT_IDLE_CYCLES     = `DURATION_IDLE_MODE;
    localparam int DEFAULT_AGING_THRESHOLD = `AGING_THRESHOLD;

endpackage

// File: rtl/monitor_timer.sv
// rtl/monitor_timer.sv - loadable down-counter; done while the count sits at zero
module monitor_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/aging_monitor.sv
// rtl/aging_monitor.sv - round-robin aging sensor scheduler/evaluator
// AGING_MONITOR_STICKY_EN makes aged flags sticky until reset.
module aging_monitor
    import aging_monitor_pkg::*;
#(
    parameter int SENSOR_COUNT    = DEFAULT_SENSOR_COUNT,
    parameter int COUNTER_WIDTH   = DEFAULT_COUNTER_WIDTH,
    parameter int MEAS_CYCLES     = DEFAULT_MEAS_CYCLES,
    parameter int IDLE_CYCLES     = DEFAULT_IDLE_CYCLES,
    parameter int AGING_THRESHOLD = DEFAULT_AGING_THRESHOLD,
    localparam int IW = (SENSOR_COUNT > 1) ? $clog2(SENSOR_COUNT) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [SENSOR_COUNT*COUNTER_WIDTH-1:0] sensor_count,
    output logic [SENSOR_COUNT-1:0]               sensor_clear,
    output logic [SENSOR_COUNT-1:0]               sensor_en,
    output logic [COUNTER_WIDTH-1:0]              result,
    output logic [IW-1:0]                         result_idx,
    output logic                                  result_valid,
    output logic [SENSOR_COUNT-1:0]               aged,
    output logic                                  round_done,
    output logic                                  busy
);

    localparam int TMAX = (MEAS_CYCLES > IDLE_CYCLES) ? MEAS_CYCLES : IDLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SENSOR_COUNT - 1);

    monitor_state_t state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     armed_q, armed_d;
    logic [COUNTER_WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]            result_idx_q, result_idx_d;
    logic [SENSOR_COUNT-1:0]  aged_q, aged_d;

    logic                     t_load;
    logic [TW-1:0]            t_val;
    logic                     t_dec;
    logic                     t_done;
    logic                     sample;
    logic                     is_aged;
    logic [COUNTER_WIDTH-1:0] cur_count;
    logic [SENSOR_COUNT-1:0]  idx_onehot;

    monitor_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst        (reset),
        .load_i     (t_load),
        .load_val_i (t_val),
        .dec_i      (t_dec),
        .done_o     (t_done)
    );

    assign cur_count  = sensor_count[idx_q*COUNTER_WIDTH +: COUNTER_WIDTH];
    assign is_aged    = (cur_count <= COUNTER_WIDTH'(AGING_THRESHOLD));
    assign idx_onehot = SENSOR_COUNT'(1) << idx_q;

    // armed_q marks that the first counted idle cycle has loaded the timer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        armed_d = armed_q;
        t_load  = 1'b0;
        t_val   = '0;
        t_dec   = 1'b0;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!enable) begin
                    armed_d = 1'b0;
                end else if (!armed_q) begin
                    if (IDLE_CYCLES == 1) begin
                        state_d = ST_CLEAR;
                    end else begin
                        armed_d = 1'b1;
                        t_load  = 1'b1;
                        t_val   = TW'(IDLE_CYCLES - 2);
                    end
                end else if (t_done) begin
                    armed_d = 1'b0;
                    state_d = ST_CLEAR;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_CLEAR: begin
                t_load  = 1'b1;
                t_val   = TW'(MEAS_CYCLES - 1);
                state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (t_done) begin
                    t_load  = 1'b1;
                    t_val   = TW'(1);
                    state_d = ST_SETTLE;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (t_done) begin
                    sample  = 1'b1;
                    state_d = ST_EVAL;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_EVAL: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture on the settle-to-eval edge so the result is visible during EVAL
    always_comb begin
        result_d     = result_q;
        result_idx_d = result_idx_q;
        aged_d       = aged_q;
        if (sample) begin
            result_d     = cur_count;
            result_idx_d = idx_q;
`ifdef AGING_MONITOR_STICKY_EN
            aged_d[idx_q] = aged_q[idx_q] | is_aged;
`else
            aged_d[idx_q] = is_aged;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            armed_q      <= 1'b0;
            result_q     <= '0;
            result_idx_q <= '0;
            aged_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            armed_q      <= armed_d;
            result_q     <= result_d;
            result_idx_q <= result_idx_d;
            aged_q       <= aged_d;
        end
    end

    assign sensor_clear = (state_q == ST_CLEAR)   ? idx_onehot : '0;
    assign sensor_en    = (state_q == ST_MEASURE) ? idx_onehot : '0;
    assign result       = result_q;
    assign result_idx   = result_idx_q;
    assign aged         = aged_q;
    assign result_valid = (state_q == ST_EVAL);
    assign round_done   = (state_q == ST_EVAL) && (idx_q == LAST_IDX);
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aging_monitor.sv
// tb/tb_aging_monitor.sv - scoreboard bench for aging_monitor
module tb_aging_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] sensor_count = '0;
    logic [1:0]  sensor_clear;
    logic [1:0]  sensor_en;
    logic [31:0] result;
    logic [0:0]  result_idx;
    logic        result_valid;
    logic [1:0]  aged;
    logic        round_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic [0:0]  idx;
        logic        rd;
        logic [1:0]  aged;
    } exp_t;

    exp_t exp_q[$];

    aging_monitor #(
        .SENSOR_COUNT    (2),
        .COUNTER_WIDTH   (32),
        .MEAS_CYCLES     (8),
        .IDLE_CYCLES     (4),
        .AGING_THRESHOLD (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sensor_count (sensor_count),
        .sensor_clear (sensor_clear),
        .sensor_en    (sensor_en),
        .result       (result),
        .result_idx   (result_idx),
        .result_valid (result_valid),
        .aged         (aged),
        .round_done   (round_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int c, input logic [31:0] r, input logic [0:0] i,
                        input logic rd, input logic [1:0] a);
        exp_t e;
        e.cyc = c; e.res = r; e.idx = i; e.rd = rd; e.aged = a;
        exp_q.push_back(e);
    endtask

    task automatic to_cycle(input int n);
        int g;
        g = 0;
        while (cyc < n && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("to_cycle", 64'(cyc), 64'(n));
    endtask

    task automatic do_reset(input logic [31:0] s0, input logic [31:0] s1);
        reset  = 1'b1;
        enable = 1'b0;
        sensor_count = {s1, s0};
        repeat (2) @(negedge clk);
        chk("reset_outputs", {sensor_clear, sensor_en, result, 1'(result_idx), result_valid,
                              aged, round_done, busy}, '0);
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        if (!reset) begin
            chk("onehot_clear", 64'($onehot0(sensor_clear)), 64'd1);
            chk("onehot_en", 64'($onehot0(sensor_en)), 64'd1);
            chk("clear_en_overlap", 64'(sensor_clear & sensor_en), 64'd0);
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_valid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result_cycle", 64'(cyc), 64'(e.cyc));
                    chk("result", 64'(result), 64'(e.res));
                    chk("result_idx", 64'(result_idx), 64'(e.idx));
                    chk("round_done", 64'(round_done), 64'(e.rd));
                    chk("aged", 64'(aged), 64'(e.aged));
                end
            end else begin
                chk("round_done_without_valid", 64'(round_done), 64'd0);
            end
        end
    end

    task automatic simple_round(input logic [31:0] s0, input logic [31:0] s1,
                                input logic [1:0] a0, input logic [1:0] a1);
        do_reset(s0, s1);
        push(15, s0, 1'b0, 1'b0, a0);
        push(27, s1, 1'b1, 1'b1, a1);
        enable = 1'b1;
        to_cycle(10);
        enable = 1'b0;
        to_cycle(30);
        chk("busy_after_round", 64'(busy), 64'd0);
    endtask

    initial begin
        // Nominal round with enable dropped mid-round
        do_reset(32'd100, 32'd50);
        push(15, 32'd100, 1'b0, 1'b0, 2'b00);
        push(27, 32'd50, 1'b1, 1'b1, 2'b00);
        enable = 1'b1;
        to_cycle(3);
        chk("clear_before_c4", 64'(sensor_clear), 64'd0);
        to_cycle(4);
        chk("clear_c4", 64'(sensor_clear), 64'b01);
        chk("busy_c4", 64'(busy), 64'd1);
        to_cycle(5);
        chk("en_c5", 64'(sensor_en), 64'b01);
        to_cycle(10);
        enable = 1'b0;
        to_cycle(12);
        chk("en_c12", 64'(sensor_en), 64'b01);
        to_cycle(13);
        chk("en_c13_settle", 64'(sensor_en), 64'd0);
        to_cycle(16);
        chk("clear_c16", 64'(sensor_clear), 64'b10);
        chk("result_hold_c16", 64'(result), 64'd100);
        to_cycle(28);
        chk("busy_c28", 64'(busy), 64'd0);
        chk("result_hold_c28", 64'(result), 64'd50);
        for (int i = 29; i <= 48; i++) begin
            to_cycle(i);
            chk("no_clear_after_disable", 64'(sensor_clear), 64'd0);
        end

        // Threshold boundaries
        simple_round(32'd6, 32'd7, 2'b01, 2'b01);
        simple_round(32'd0, 32'hFFFF_FFFF, 2'b01, 2'b01);

        // Sticky vs latest-measurement flags over two rounds
        do_reset(32'd100, 32'd3);
        push(15, 32'd100, 1'b0, 1'b0, 2'b00);
        push(27, 32'd3, 1'b1, 1'b1, 2'b10);
        push(43, 32'd100, 1'b0, 1'b0, 2'b10);
`ifdef AGING_MONITOR_STICKY_EN
        push(55, 32'd90, 1'b1, 1'b1, 2'b10);
`else
        push(55, 32'd90, 1'b1, 1'b1, 2'b00);
`endif
        enable = 1'b1;
        to_cycle(30);
        sensor_count = {32'd90, 32'd100};
        to_cycle(32);
        chk("clear_round2_c32", 64'(sensor_clear), 64'b01);
        to_cycle(40);
        enable = 1'b0;
        to_cycle(58);
        chk("busy_after_round2", 64'(busy), 64'd0);

        // Reset during MEASURE
        do_reset(32'd100, 32'd50);
        enable = 1'b1;
        to_cycle(8);
        chk("en_c8_before_reset", 64'(sensor_en), 64'b01);
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {sensor_clear, sensor_en, result, 1'(result_idx), result_valid,
                                    aged, round_done, busy}, '0);
        @(negedge clk);
        reset = 1'b0;
        push(15, 32'd100, 1'b0, 1'b0, 2'b00);
        push(27, 32'd50, 1'b1, 1'b1, 2'b00);
        to_cycle(3);
        chk("clear_c3_after_reset", 64'(sensor_clear), 64'd0);
        to_cycle(4);
        chk("clear_c4_after_reset", 64'(sensor_clear), 64'b01);
        to_cycle(10);
        enable = 1'b0;
        to_cycle(30);
        chk("busy_end", 64'(busy), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
